// File: rtl/uart_cmd_pkg.sv
// Shared command-controller definitions: opcodes, FSM state encoding, operand addresses.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_TX_SEND
    } state_e;

    // States in which an incoming byte belongs to a frame (and may abort it).
    function automatic logic is_rx_state(input logic [3:0] s);
        return !(s inside {ST_RD_WAIT, ST_ALU_WAIT, ST_TX_SEND});
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of RX, register-file, ALU and TX signals around the command controller.
interface uart_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ALU_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_data_valid;
    logic                  rx_par_error;
    logic                  rx_stop_error;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic                  rf_wr_en;
    logic [DATA_WIDTH-1:0] rf_wr_data;
    logic                  rf_rd_en;
    logic [DATA_WIDTH-1:0] rf_rd_data;
    logic                  rf_rd_valid;
    logic [3:0]            alu_fun;
    logic                  alu_en;
    logic [ALU_WIDTH-1:0]  alu_out;
    logic                  alu_out_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_data_valid;
    logic                  tx_busy;
    logic                  frame_err;

    modport master (
        input  rx_data, rx_data_valid, rx_par_error, rx_stop_error,
        input  rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_busy,
        output rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
        output alu_fun, alu_en, tx_data, tx_data_valid, frame_err
    );

    modport slave (
        output rx_data, rx_data_valid, rx_par_error, rx_stop_error,
        output rf_rd_data, rf_rd_valid, alu_out, alu_out_valid, tx_busy,
        input  rf_addr, rf_wr_en, rf_wr_data, rf_rd_en,
        input  alu_fun, alu_en, tx_data, tx_data_valid, frame_err
    );
endinterface

// File: rtl/uart_cmd_tx_seq.sv
// Sends 1..2 result bytes (low first) over the TX valid/busy handshake; done pulses after the last byte.
// Request only while tx_busy=0, hold data until busy seen high, next byte only after busy falls.
module uart_cmd_tx_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ALU_WIDTH-1:0]  data,
    input  logic [1:0]            nbytes,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_data_valid,
    output logic                  done
);
    localparam logic [1:0] T_IDLE      = 2'd0;
    localparam logic [1:0] T_WAIT_FREE = 2'd1;
    localparam logic [1:0] T_HOLD      = 2'd2;
    localparam logic [1:0] T_WAIT_DONE = 2'd3;

    logic [1:0]           state;
    logic [1:0]           left;
    logic [ALU_WIDTH-1:0] shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= T_IDLE;
            left          <= '0;
            shreg         <= '0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                T_IDLE: if (start) begin
                    shreg <= data;
                    left  <= nbytes;
                    state <= T_WAIT_FREE;
                end
                T_WAIT_FREE: if (!tx_busy) begin
                    tx_data       <= shreg[DATA_WIDTH-1:0];
                    tx_data_valid <= 1'b1;
                    state         <= T_HOLD;
                end
                T_HOLD: if (tx_busy) begin
                    tx_data_valid <= 1'b0;
                    shreg         <= shreg >> DATA_WIDTH;
                    left          <= left - 2'd1;
                    state         <= T_WAIT_DONE;
                end
                default: if (!tx_busy) begin
                    if (left == 2'd0) begin
                        done  <= 1'b1;
                        state <= T_IDLE;
                    end else begin
                        state <= T_WAIT_FREE;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Decodes UART command frames into register-file writes/reads and ALU runs; strobes 1 cycle after the last byte.
// Results go back through uart_cmd_tx_seq; bytes arriving while waiting or transmitting are dropped.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ALU_WIDTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_cmd_ctrl_if.master bus
);
    localparam logic [3:0] IDLE     = ST_IDLE;
    localparam logic [3:0] WR_ADDR  = ST_WR_ADDR;
    localparam logic [3:0] WR_DATA  = ST_WR_DATA;
    localparam logic [3:0] RD_ADDR  = ST_RD_ADDR;
    localparam logic [3:0] RD_WAIT  = ST_RD_WAIT;
    localparam logic [3:0] OP_A     = ST_OP_A;
    localparam logic [3:0] OP_B     = ST_OP_B;
    localparam logic [3:0] ALU_FUN  = ST_ALU_FUN;
    localparam logic [3:0] ALU_WAIT = ST_ALU_WAIT;
    localparam logic [3:0] TX_SEND  = ST_TX_SEND;

    logic [3:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ALU_WIDTH-1:0]  result;
    logic [1:0]            nbytes;
    logic                  tx_start;
    logic                  tx_done;
    logic                  rx_bad;
    logic                  rx_vld;

    assign rx_bad = bus.rx_par_error | bus.rx_stop_error;
    assign rx_vld = bus.rx_data_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            addr_q         <= '0;
            result         <= '0;
            nbytes         <= '0;
            tx_start       <= 1'b0;
            bus.rf_addr    <= '0;
            bus.rf_wr_en   <= 1'b0;
            bus.rf_wr_data <= '0;
            bus.rf_rd_en   <= 1'b0;
            bus.alu_fun    <= '0;
            bus.alu_en     <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.rf_wr_en  <= 1'b0;
            bus.rf_rd_en  <= 1'b0;
            bus.alu_en    <= 1'b0;
            bus.frame_err <= 1'b0;
            tx_start      <= 1'b0;
            // A corrupted byte kills the frame before any strobe can fire.
            if (rx_vld && rx_bad && is_rx_state(state)) begin
                bus.frame_err <= 1'b1;
                state         <= IDLE;
            end else begin
                case (state)
                    IDLE: if (rx_vld) begin
                        case (bus.rx_data)
                            CMD_WR:      state <= WR_ADDR;
                            CMD_RD:      state <= RD_ADDR;
                            CMD_ALU_OP:  state <= OP_A;
                            CMD_ALU_NOP: state <= ALU_FUN;
                            default:     bus.frame_err <= 1'b1;
                        endcase
                    end
                    WR_ADDR: if (rx_vld) begin
                        addr_q <= bus.rx_data[ADDR_WIDTH-1:0];
                        state  <= WR_DATA;
                    end
                    WR_DATA: if (rx_vld) begin
                        bus.rf_addr    <= addr_q;
                        bus.rf_wr_data <= bus.rx_data;
                        bus.rf_wr_en   <= 1'b1;
                        state          <= IDLE;
                    end
                    RD_ADDR: if (rx_vld) begin
                        bus.rf_addr  <= bus.rx_data[ADDR_WIDTH-1:0];
                        bus.rf_rd_en <= 1'b1;
                        state        <= RD_WAIT;
                    end
                    RD_WAIT: if (bus.rf_rd_valid) begin
                        result   <= ALU_WIDTH'(bus.rf_rd_data);
                        nbytes   <= 2'd1;
                        tx_start <= 1'b1;
                        state    <= TX_SEND;
                    end
                    OP_A: if (rx_vld) begin
                        bus.rf_addr    <= ADDR_WIDTH'(OPA_ADDR);
                        bus.rf_wr_data <= bus.rx_data;
                        bus.rf_wr_en   <= 1'b1;
                        state          <= OP_B;
                    end
                    OP_B: if (rx_vld) begin
                        bus.rf_addr    <= ADDR_WIDTH'(OPB_ADDR);
                        bus.rf_wr_data <= bus.rx_data;
                        bus.rf_wr_en   <= 1'b1;
                        state          <= ALU_FUN;
                    end
                    ALU_FUN: if (rx_vld) begin
                        bus.alu_fun <= bus.rx_data[3:0];
                        bus.alu_en  <= 1'b1;
                        state       <= ALU_WAIT;
                    end
                    ALU_WAIT: if (bus.alu_out_valid) begin
                        result   <= bus.alu_out;
                        nbytes   <= 2'd2;
                        tx_start <= 1'b1;
                        state    <= TX_SEND;
                    end
                    TX_SEND: if (tx_done) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    uart_cmd_tx_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .ALU_WIDTH  (ALU_WIDTH)
    ) u_tx_seq (
        .clk           (clk),
        .rst           (rst),
        .start         (tx_start),
        .data          (result),
        .nbytes        (nbytes),
        .tx_busy       (bus.tx_busy),
        .tx_data       (bus.tx_data),
        .tx_data_valid (bus.tx_data_valid),
        .done          (tx_done)
    );
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Table-driven frames with an event scoreboard; RF, ALU and UART TX are modelled by responder processes.
module tb_uart_cmd_ctrl;
    import uart_cmd_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_cmd_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16)) bus ();

    uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam int EV_WR = 0, EV_RD = 1, EV_ALU = 2, EV_TX = 3, EV_FERR = 4;

    typedef struct {
        int          kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    typedef struct {
        int          n;
        logic [7:0]  b [4];
        int          err_at;
        bit          stop;
        logic [15:0] ret;
        int          nev;
        ev_t         ev [5];
    } vec_t;

    ev_t         sb[$];
    vec_t        vt[10];
    int          checks = 0;
    int          passes = 0;
    logic [7:0]  rd_ret = '0;
    logic [15:0] alu_ret = '0;
    int          alu_lat = 3;
    logic [3:0]  rd_addr_seen;
    logic [3:0]  alu_fun_seen;
    logic        prev_vld = 1'b0;
    logic [7:0]  held_byte = '0;

    function automatic ev_t mk(int k, logic [15:0] a, logic [15:0] b);
        ev_t e;
        e.kind = k; e.a = a; e.b = b;
        return e;
    endfunction

    function automatic vec_t mkv(int n, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                 logic [7:0] b3, int err_at, bit stop, logic [15:0] ret);
        vec_t x;
        x.n = n; x.b[0] = b0; x.b[1] = b1; x.b[2] = b2; x.b[3] = b3;
        x.err_at = err_at; x.stop = stop; x.ret = ret; x.nev = 0;
        for (int i = 0; i < 5; i++) x.ev[i] = mk(0, 0, 0);
        return x;
    endfunction

    function automatic vec_t add(vec_t x, ev_t e);
        x.ev[x.nev] = e;
        x.nev++;
        return x;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic observe(ev_t got);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL unexpected_event: got kind=%0d a=%h b=%h, required no event",
                     got.kind, got.a, got.b);
        end else begin
            e = sb.pop_front();
            if (got.kind === e.kind && got.a === e.a && got.b === e.b) passes++;
            else $display("FAIL event: got kind=%0d a=%h b=%h, required kind=%0d a=%h b=%h",
                          got.kind, got.a, got.b, e.kind, e.a, e.b);
        end
    endtask

    // Output monitor: samples just after the active edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (bus.rf_wr_en)  observe(mk(EV_WR, 16'(bus.rf_addr), 16'(bus.rf_wr_data)));
            if (bus.rf_rd_en)  observe(mk(EV_RD, 16'(bus.rf_addr), 0));
            if (bus.alu_en)    observe(mk(EV_ALU, 16'(bus.alu_fun), 0));
            if (bus.frame_err) observe(mk(EV_FERR, 0, 0));
            if (bus.tx_data_valid && !prev_vld) begin
                observe(mk(EV_TX, 16'(bus.tx_data), 0));
                chk("tx_raise_while_not_busy", 16'(bus.tx_busy), 0);
                held_byte = bus.tx_data;
            end
            if (bus.tx_data_valid && prev_vld) chk("tx_data_stable", 16'(bus.tx_data), 16'(held_byte));
            if (!bus.tx_data_valid && prev_vld) chk("tx_drop_after_busy", 16'(bus.tx_busy), 1);
        end
        prev_vld = bus.tx_data_valid;
    end

    initial begin
        bus.rf_rd_valid = 1'b0;
        bus.rf_rd_data  = '0;
        forever begin
            @(negedge clk);
            if (bus.rf_rd_en) begin
                rd_addr_seen = bus.rf_addr;
                repeat (2) @(negedge clk);
                bus.rf_rd_data  = rd_ret;
                bus.rf_rd_valid = 1'b1;
                chk("rf_addr_held", 16'(bus.rf_addr), 16'(rd_addr_seen));
                @(negedge clk);
                bus.rf_rd_valid = 1'b0;
            end
        end
    end

    initial begin
        bus.alu_out_valid = 1'b0;
        bus.alu_out       = '0;
        forever begin
            @(negedge clk);
            if (bus.alu_en) begin
                alu_fun_seen = bus.alu_fun;
                repeat (alu_lat) @(negedge clk);
                bus.alu_out       = alu_ret;
                bus.alu_out_valid = 1'b1;
                chk("alu_fun_held", 16'(bus.alu_fun), 16'(alu_fun_seen));
                @(negedge clk);
                bus.alu_out_valid = 1'b0;
            end
        end
    end

    // UART TX model: accepts a request two cycles late, stays busy four cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_data_valid && !bus.tx_busy) begin
                repeat (2) @(negedge clk);
                bus.tx_busy = 1'b1;
                repeat (4) @(negedge clk);
                bus.tx_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(logic [7:0] b, bit par, bit stop);
        bus.rx_data       = b;
        bus.rx_data_valid = 1'b1;
        bus.rx_par_error  = par;
        bus.rx_stop_error = stop;
        @(negedge clk);
        bus.rx_data_valid = 1'b0;
        bus.rx_par_error  = 1'b0;
        bus.rx_stop_error = 1'b0;
    endtask

    task automatic wait_empty(int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL timeout: %0d events pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic drain();
        wait_empty(300);
        repeat (16) @(negedge clk);
    endtask

    task automatic run_vec(vec_t x);
        rd_ret  = x.ret[7:0];
        alu_ret = x.ret;
        for (int k = 0; k < x.nev; k++) sb.push_back(x.ev[k]);
        for (int k = 0; k < x.n; k++)
            send_byte(x.b[k], (k == x.err_at) && !x.stop, (k == x.err_at) && x.stop);
        drain();
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_rf_addr"},       16'(bus.rf_addr), 0);
        chk({tag, "_rf_wr_en"},      16'(bus.rf_wr_en), 0);
        chk({tag, "_rf_wr_data"},    16'(bus.rf_wr_data), 0);
        chk({tag, "_rf_rd_en"},      16'(bus.rf_rd_en), 0);
        chk({tag, "_alu_fun"},       16'(bus.alu_fun), 0);
        chk({tag, "_alu_en"},        16'(bus.alu_en), 0);
        chk({tag, "_tx_data"},       16'(bus.tx_data), 0);
        chk({tag, "_tx_data_valid"}, 16'(bus.tx_data_valid), 0);
        chk({tag, "_frame_err"},     16'(bus.frame_err), 0);
    endtask

    initial begin
        int t;
        bus.rx_data       = '0;
        bus.rx_data_valid = 1'b0;
        bus.rx_par_error  = 1'b0;
        bus.rx_stop_error = 1'b0;

        vt[0] = add(mkv(3, 8'hAA, 8'h05, 8'h3C, 8'h00, -1, 0, 16'h0000), mk(EV_WR, 5, 16'h3C));
        vt[1] = add(add(mkv(2, 8'hBB, 8'h05, 8'h00, 8'h00, -1, 0, 16'h003C),
                        mk(EV_RD, 5, 0)), mk(EV_TX, 16'h3C, 0));
        vt[2] = add(add(add(add(add(mkv(4, 8'hCC, 8'h10, 8'h20, 8'h01, -1, 0, 16'h0030),
                        mk(EV_WR, 0, 16'h10)), mk(EV_WR, 1, 16'h20)), mk(EV_ALU, 1, 0)),
                        mk(EV_TX, 16'h30, 0)), mk(EV_TX, 16'h00, 0));
        vt[3] = add(mkv(3, 8'hAA, 8'h02, 8'h77, 8'h00, 2, 0, 16'h0000), mk(EV_FERR, 0, 0));
        vt[4] = add(add(add(mkv(2, 8'hDD, 8'h02, 8'h00, 8'h00, -1, 0, 16'h1234),
                        mk(EV_ALU, 2, 0)), mk(EV_TX, 16'h34, 0)), mk(EV_TX, 16'h12, 0));
        vt[5] = add(mkv(1, 8'h55, 8'h00, 8'h00, 8'h00, -1, 0, 16'h0000), mk(EV_FERR, 0, 0));
        vt[6] = add(mkv(3, 8'hAA, 8'hF3, 8'h7E, 8'h00, -1, 0, 16'h0000), mk(EV_WR, 3, 16'h7E));
        vt[7] = add(mkv(2, 8'hBB, 8'h00, 8'h00, 8'h00, 1, 1, 16'h0000), mk(EV_FERR, 0, 0));
        vt[8] = add(add(add(mkv(2, 8'hDD, 8'h1F, 8'h00, 8'h00, -1, 0, 16'hABCD),
                        mk(EV_ALU, 16'hF, 0)), mk(EV_TX, 16'hCD, 0)), mk(EV_TX, 16'hAB, 0));
        vt[9] = add(add(add(mkv(4, 8'hCC, 8'h01, 8'h02, 8'h03, 2, 0, 16'h0000),
                        mk(EV_WR, 0, 16'h01)), mk(EV_FERR, 0, 0)), mk(EV_FERR, 0, 0));

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vt[i]);

        // Back-to-back frames, then an unknown opcode with no gap.
        sb.push_back(mk(EV_WR, 1, 16'h11));
        sb.push_back(mk(EV_WR, 2, 16'h22));
        sb.push_back(mk(EV_FERR, 0, 0));
        send_byte(CMD_WR, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'h11, 0, 0);
        send_byte(CMD_WR, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h22, 0, 0);
        send_byte(8'h55, 0, 0);
        drain();

        // A full write frame arriving during ALU_WAIT must vanish.
        alu_lat = 10;
        alu_ret = 16'h0102;
        sb.push_back(mk(EV_ALU, 4, 0));
        sb.push_back(mk(EV_TX, 16'h02, 0));
        sb.push_back(mk(EV_TX, 16'h01, 0));
        send_byte(CMD_ALU_NOP, 0, 0); send_byte(8'h04, 0, 0);
        send_byte(CMD_WR, 0, 0); send_byte(8'h03, 0, 0); send_byte(8'h44, 0, 0);
        drain();
        alu_lat = 3;

        // Reset between the two response bytes: the high byte must never appear.
        alu_ret = 16'hBEEF;
        sb.push_back(mk(EV_ALU, 1, 0));
        sb.push_back(mk(EV_TX, 16'hEF, 0));
        send_byte(CMD_ALU_NOP, 0, 0); send_byte(8'h01, 0, 0);
        wait_empty(200);
        t = 0;
        while (bus.tx_data_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.tx_data_valid) begin
            checks++;
            $display("FAIL tx_busy_wait: tx_data_valid still 1, required 0");
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midtx_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        sb.push_back(mk(EV_WR, 7, 16'h99));
        send_byte(CMD_WR, 0, 0); send_byte(8'h07, 0, 0); send_byte(8'h99, 0, 0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
